// File: rtl/car_racer_pkg.sv
// Shared types and constants for the car racer obstacle path.
package car_racer_pkg;

   localparam int LANES_DEFAULT = 3;
   localparam int GAP_W         = 5;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      SAMPLE,
      OFFER
   } state_t;

   typedef logic [1:0] lane_t;

   localparam lane_t LANE_NONE = 2'd3;

   // Folds an out-of-range lane onto lane 1, then steps past the previous lane.
   function automatic lane_t map_lane(input lane_t raw, input lane_t prev, input int lanes);
      lane_t last;
      lane_t lane;
      last = lane_t'(lanes - 1);
      lane = (raw > last) ? lane_t'(1) : raw;
      if (lane == prev) begin
         lane = (lane == last) ? lane_t'(0) : lane + lane_t'(1);
      end
      return lane;
   endfunction

endpackage

// File: rtl/frame_gap_counter.sv
// Frame gap counter: loadable, decrements on a qualified tick, saturates at zero.
module frame_gap_counter
   import car_racer_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [GAP_W-1:0] load_value,
   input  logic             tick,
   output logic             zero
);

   logic [GAP_W-1:0] count;

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/obstacle_spawner.sv
// Turns LFSR words into obstacle spawn requests with a randomized frame gap
// and no back-to-back spawns in the same lane.
module obstacle_spawner
   import car_racer_pkg::*;
#(
   parameter int N       = 7,
   parameter int LANES   = LANES_DEFAULT,
   parameter int MIN_GAP = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         frame_tick,
   input  logic [N-1:0] rand_num,
   output logic         spawn_valid,
   input  logic         spawn_ready,
   output logic [1:0]   spawn_lane,
   output logic [1:0]   spawn_speed,
   output logic [7:0]   spawn_count
);

   localparam logic [GAP_W-1:0] MIN_GAP_W = GAP_W'(MIN_GAP);

   state_t           state;
   lane_t            prev_lane;
   logic [GAP_W-1:0] next_gap;
   logic             accept;
   logic             gap_load;
   logic             gap_tick;
   logic             gap_zero;
   logic [GAP_W-1:0] gap_value;

   // A falling enable suppresses the handshake in the same cycle.
   assign accept    = enable && (state == OFFER) && spawn_valid && spawn_ready;
   assign gap_load  = enable && ((state == IDLE) || accept);
   assign gap_value = (state == IDLE) ? MIN_GAP_W : next_gap;
   assign gap_tick  = enable && (state == GAP) && frame_tick;

   frame_gap_counter u_gap (
      .clock      (clock),
      .reset      (reset),
      .load       (gap_load),
      .load_value (gap_value),
      .tick       (gap_tick),
      .zero       (gap_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         spawn_valid <= 1'b0;
         spawn_lane  <= '0;
         spawn_speed <= '0;
         spawn_count <= '0;
         prev_lane   <= LANE_NONE;
         next_gap    <= '0;
      end else if (!enable) begin
         state       <= IDLE;
         spawn_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= GAP;
            GAP: begin
               if (frame_tick && gap_zero) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               spawn_lane  <= map_lane(rand_num[1:0], prev_lane, LANES);
               spawn_speed <= rand_num[3:2];
               next_gap    <= MIN_GAP_W + GAP_W'(rand_num[6:4]);
               spawn_valid <= 1'b1;
               state       <= OFFER;
            end
            OFFER: begin
               if (accept) begin
                  prev_lane   <= spawn_lane;
                  spawn_count <= spawn_count + 8'd1;
                  spawn_valid <= 1'b0;
                  state       <= GAP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   generate
      if (N > 7) begin : g_wide
         logic unused_high;
         assign unused_high = ^rand_num[N-1:7];
      end
   endgenerate

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: a small lane/gap model predicts each offer.
`timescale 1ns/1ps
module tb_obstacle_spawner;
   import car_racer_pkg::*;

   localparam int N       = 7;
   localparam int LANES   = 3;
   localparam int MIN_GAP = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         enable;
   logic         frame_tick;
   logic [N-1:0] rand_num;
   logic         spawn_valid;
   logic         spawn_ready;
   logic [1:0]   spawn_lane;
   logic [1:0]   spawn_speed;
   logic [7:0]   spawn_count;

   always #5 clock = ~clock;

   obstacle_spawner #(.N(N), .LANES(LANES), .MIN_GAP(MIN_GAP)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .frame_tick  (frame_tick),
      .rand_num    (rand_num),
      .spawn_valid (spawn_valid),
      .spawn_ready (spawn_ready),
      .spawn_lane  (spawn_lane),
      .spawn_speed (spawn_speed),
      .spawn_count (spawn_count)
   );

   typedef struct {
      logic [1:0] lane;
      logic [1:0] speed;
      int         gap;
   } spawn_t;

   spawn_t sb[$];
   spawn_t offer;
   int     n_vectors     = 0;
   int     n_miscompares = 0;
   int     prev_m;
   int     count_m;
   int     gap_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] exp_lane(input logic [1:0] raw);
      int l;
      l = (int'(raw) >= LANES) ? 1 : int'(raw);
      if (l == prev_m) l = (l + 1) % LANES;
      return 2'(l);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      rand_num = N'($urandom);
   endtask

   task automatic frame(input int spacing);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (spacing - 1) step();
      @(negedge clock);
      check("gap_valid", spawn_valid, 0);
   endtask

   task automatic gap_phase(input int spacing);
      repeat (gap_m) frame(spacing);
   endtask

   // The spawning tick; rnd is on rand_num only for the SAMPLE edge.
   task automatic spawn_tick(input logic [6:0] rnd);
      spawn_t e;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      rand_num   = N'(rnd);
      e.lane  = exp_lane(rnd[1:0]);
      e.speed = rnd[3:2];
      e.gap   = MIN_GAP + int'(rnd[6:4]);
      sb.push_back(e);
      @(negedge clock);
      check("valid_tick_plus1", spawn_valid, 0);
      step();
      @(negedge clock);
      check("valid_tick_plus2", spawn_valid, 1);
      offer = sb.pop_front();
      check("lane", spawn_lane, offer.lane);
      check("speed", spawn_speed, offer.speed);
   endtask

   task automatic accept(input logic with_tick);
      spawn_ready = 1'b1;
      frame_tick  = with_tick;
      step();
      frame_tick = 1'b0;
      prev_m  = int'(offer.lane);
      count_m = (count_m + 1) % 256;
      gap_m   = offer.gap;
      @(negedge clock);
      check("valid_after_accept", spawn_valid, 0);
      check("count", spawn_count, count_m);
   endtask

   task automatic reset_dut();
      reset       = 1'b1;
      enable      = 1'b1;
      frame_tick  = 1'b1;
      spawn_ready = 1'b1;
      repeat (3) step();
      @(negedge clock);
      check("reset_valid", spawn_valid, 0);
      check("reset_lane", spawn_lane, 0);
      check("reset_speed", spawn_speed, 0);
      check("reset_count", spawn_count, 0);
      reset      = 1'b0;
      frame_tick = 1'b0;
      step();
      prev_m  = 3;
      count_m = 0;
      gap_m   = MIN_GAP;
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      frame_tick  = 1'b0;
      spawn_ready = 1'b0;
      rand_num    = '0;

      // Reset, first spawn after MIN_GAP+1 ticks, field decode.
      reset_dut();
      gap_phase(10);
      spawn_tick(7'b0101110);
      check("decode_lane", spawn_lane, 2);
      check("decode_speed", spawn_speed, 3);
      accept(1'b1);
      gap_phase(10);
      spawn_tick(7'($urandom));
      accept(1'b0);

      // Lane remap and no-repeat from a fresh reset.
      reset_dut();
      gap_phase(4);
      spawn_tick(7'b0000011);
      check("remap_raw3", spawn_lane, 1);
      accept(1'b0);
      gap_phase(4);
      spawn_tick(7'b0000101);
      check("repeat_raw1", spawn_lane, 2);
      accept(1'b0);
      gap_phase(4);
      spawn_tick(7'b0000010);
      check("repeat_raw2", spawn_lane, 0);
      accept(1'b0);

      // Backpressure: 20 stalled clocks with 3 ignored ticks.
      spawn_ready = 1'b0;
      gap_phase(4);
      spawn_tick(7'($urandom));
      for (int i = 1; i <= 20; i++) begin
         frame_tick = (i % 6 == 0);
         step();
         frame_tick = 1'b0;
         @(negedge clock);
         check("stall_valid", spawn_valid, 1);
         check("stall_lane", spawn_lane, offer.lane);
         check("stall_speed", spawn_speed, offer.speed);
         check("stall_count", spawn_count, count_m);
      end
      accept(1'b0);
      gap_phase(4);
      spawn_tick(7'($urandom));
      accept(1'b0);

      // Abort: enable falls together with an accepting handshake.
      spawn_ready = 1'b0;
      gap_phase(4);
      spawn_tick(7'($urandom));
      enable      = 1'b0;
      spawn_ready = 1'b1;
      step();
      @(negedge clock);
      check("abort_valid", spawn_valid, 0);
      check("abort_state", dut.state, IDLE);
      check("abort_count", spawn_count, count_m);
      repeat (3) frame(3);
      check("idle_state", dut.state, IDLE);
      enable = 1'b1;
      step();
      gap_m = MIN_GAP;
      gap_phase(4);
      spawn_tick(7'($urandom));
      accept(1'b0);

      // Count wrap over 256 accepted spawns.
      reset_dut();
      for (int k = 0; k < 256; k++) begin
         gap_phase(2);
         spawn_tick(7'($urandom));
         check("no_repeat", 32'(int'(spawn_lane) != prev_m), 1);
         accept(1'b0);
      end
      check("wrap_count", spawn_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
